seg_dyn_drv: RTL and testbench

//  Parametrised dynamic-scan driver for an N-digit, 8-segment display (next generation of the fixed 6-digit scanner).

---
 rtl/seg_dyn_drv_pkg.sv | 11 +
 rtl/seg_dyn_drv_if.sv | 13 +
 rtl/seg_dyn_drv_bin2bcd_seq.sv | 73 +++++++
 rtl/seg_dyn_drv.sv | 95 +++++++++
 tb/tb_seg_dyn_drv.sv | 139 +++++++++++++
 5 files changed

// File: rtl/seg_dyn_drv_pkg.sv
// seg_dyn_drv_pkg: segment codes, converter states and digit decoder for the scan driver
package seg_dyn_drv_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} cvt_st_e;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_LUT [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                         8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  function automatic logic [7:0] dig2seg(input logic [3:0] n);
    return n < 4'd10 ? SEG_LUT[n] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/seg_dyn_drv_if.sv
// seg_dyn_drv_if: data source inputs and display pin outputs of the scan driver
interface seg_dyn_drv_if #(parameter int DIGITS = 6, parameter int DATA_W = 20);
  logic [DATA_W-1:0] data;
  logic [DIGITS-1:0] point;
  logic              sign;
  logic              seg_en;
  logic [7:0]        seg;
  logic [DIGITS-1:0] sel;
  logic              ovf;
  logic              cvt_done;
  modport master (output data, point, sign, seg_en, input seg, sel, ovf, cvt_done);
  modport slave (input data, point, sign, seg_en, output seg, sel, ovf, cvt_done);
endinterface

// File: rtl/seg_dyn_drv_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per clock, with sticky overflow carry
module bin2bcd_seq
  import seg_dyn_drv_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [DATA_W-1:0]   data_i,
  output logic                load_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                carry_o,
  output logic                done_o
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(DATA_W+1);
  cvt_st_e st_q, st_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  // add-3 correction on every nibble that will reach 10 or more after the shift
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  // next state: capture in IDLE, DATA_W shifts, then one DONE cycle
  always_comb begin
    st_d = st_q;
    bcd_d = bcd_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    unique case (st_q)
      IDLE: begin
        bcd_d = '0;
        sh_d = data_i;
        cnt_d = '0;
        carry_d = 1'b0;
        st_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {adj[BW-2:0], sh_q[DATA_W-1]};
        sh_d = sh_q << 1;
        carry_d = carry_q | adj[BW-1];
        cnt_d = cnt_q + CW'(1);
        st_d = cnt_q == CW'(DATA_W-1) ? DONE : SHIFT;
      end
      default: st_d = IDLE;
    endcase
  end
  // converter state register
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      st_q <= IDLE;
      bcd_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
    end else begin
      st_q <= st_d;
      bcd_q <= bcd_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
    end
  assign load_o = st_q == IDLE;
  assign done_o = st_q == DONE;
  assign bcd_o = bcd_q;
  assign carry_o = carry_q;
endmodule

// File: rtl/seg_dyn_drv.sv
// seg_dyn_drv: N-digit dynamic-scan display driver with BCD conversion, blanking, sign and overflow
module seg_dyn_drv
  import seg_dyn_drv_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int DATA_W      = 20,
  parameter int SCAN_CNT    = 49_999,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  seg_dyn_drv_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW = SCAN_CNT > 0 ? $clog2(SCAN_CNT+1) : 1;
  logic load, done, carry;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0] point_q;
  logic sign_q;
  logic [7:0] disp_q [DIGITS];
  logic [7:0] disp_d [DIGITS];
  logic ovf_q, ovf_d, cvt_done_q;
  logic [SW-1:0] scan_q;
  logic [IW-1:0] idx_q;
  logic [7:0] seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  int top;
  bin2bcd_seq #(.DIGITS(DIGITS), .DATA_W(DATA_W)) u_cvt (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .data_i   (bus.data),
    .load_o   (load),
    .bcd_o    (bcd),
    .carry_o  (carry),
    .done_o   (done)
  );
  // blanking, sign placement and overflow for the finished conversion
  always_comb begin
    top = 0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i+:4] != 4'd0 || point_q[i]) top = i;
    ovf_d = carry | (sign_q && top == DIGITS-1);
    for (int i = 0; i < DIGITS; i++)
      disp_d[i] = ovf_d ? SEG_MINUS :
                  i <= top ? dig2seg(bcd[4*i+:4]) | {point_q[i], 7'd0} :
                  (sign_q && i == top+1) ? SEG_MINUS : SEG_BLANK;
  end
  // capture point/sign alongside the data, commit display regs when conversion ends
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      point_q <= '0;
      sign_q <= 1'b0;
      disp_q <= '{default: SEG_BLANK};
      ovf_q <= 1'b0;
      cvt_done_q <= 1'b0;
    end else begin
      if (load) begin
        point_q <= bus.point;
        sign_q <= bus.sign;
      end
      if (done) begin
        disp_q <= disp_d;
        ovf_q <= ovf_d;
      end
      cvt_done_q <= done;
    end
  // scan counter and digit index
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      scan_q <= '0;
      idx_q <= '0;
    end else begin
      scan_q <= scan_q == SW'(SCAN_CNT) ? '0 : scan_q + SW'(1);
      if (scan_q == SW'(SCAN_CNT)) idx_q <= idx_q == IW'(DIGITS-1) ? '0 : idx_q + IW'(1);
    end
  // select and segment pattern both derived from the same index
  always_comb begin
    sel_d = bus.seg_en ? DIGITS'(1) << idx_q : '0;
    seg_d = bus.seg_en ? disp_q[idx_q] : SEG_BLANK;
  end
  // output registers so sel and seg switch on the same edge
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sel_q <= '0;
      seg_q <= '0;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  assign bus.seg = seg_q ^ {8{SEG_ACT_LOW}};
  assign bus.sel = sel_q ^ {DIGITS{SEL_ACT_LOW}};
  assign bus.ovf = ovf_q;
  assign bus.cvt_done = cvt_done_q;
endmodule

// File: tb/tb_seg_dyn_drv.sv
// tb_seg_dyn_drv: directed checks of conversion, blanking, sign, overflow, scan, enable and reset
module tb_seg_dyn_drv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errs = 0;
  logic [7:0] cap [6];
  seg_dyn_drv_if #(.DIGITS(6), .DATA_W(20)) bus ();
  seg_dyn_drv #(.DIGITS(6), .DATA_W(20), .SCAN_CNT(3), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = bus.cvt_done;
    end
    if (!seen) chk("cvt_done_timeout", 32'd0, 32'd1);
  endtask
  task automatic apply(input logic [19:0] d, input logic [5:0] p, input logic s);
    @(negedge clk);
    bus.data = d;
    bus.point = p;
    bus.sign = s;
    wait_done();
    wait_done();
  endtask
  task automatic check_disp(input string name, input logic [47:0] exp, input logic exp_ovf);
    logic [5:0] m;
    for (int i = 0; i < 6; i++) cap[i] = 8'h00;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        m = 6'b1 << i;
        if (bus.sel == ~m) cap[i] = bus.seg;
      end
    end
    for (int i = 0; i < 6; i++) chk($sformatf("%s_d%0d", name, i), {24'd0, cap[i]}, {24'd0, exp[8*i+:8]});
    chk({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bit seen;
    bus.data = '0;
    bus.point = '0;
    bus.sign = 1'b0;
    bus.seg_en = 1'b1;
    #3;
    chk("rst_sel", {26'd0, bus.sel}, 32'h3F);
    chk("rst_seg", {24'd0, bus.seg}, 32'hFF);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_done", {31'd0, bus.cvt_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("scan_first", {26'd0, bus.sel}, 32'h3E);
    repeat (3) @(posedge clk);
    #1;
    chk("scan_hold", {26'd0, bus.sel}, 32'h3E);
    @(posedge clk);
    #1;
    chk("scan_d1", {26'd0, bus.sel}, 32'h3D);
    repeat (4) @(posedge clk);
    #1;
    chk("scan_d2", {26'd0, bus.sel}, 32'h3B);
    apply(20'd0, 6'b0, 1'b0);
    check_disp("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, 1'b0);
    apply(20'd123456, 6'b0, 1'b0);
    check_disp("n123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}, 1'b0);
    @(negedge clk);
    chk("en_before", {31'd0, bus.sel == 6'h3F}, 32'd0);
    bus.seg_en = 1'b0;
    @(posedge clk);
    #1;
    chk("en_off_sel", {26'd0, bus.sel}, 32'h3F);
    chk("en_off_seg", {24'd0, bus.seg}, 32'hFF);
    bus.seg_en = 1'b1;
    apply(20'd99, 6'b0, 1'b1);
    check_disp("neg99", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h90, 8'h90}, 1'b0);
    apply(20'd5, 6'b000100, 1'b0);
    check_disp("pt5", {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92}, 1'b0);
    apply(20'd7, 6'b000010, 1'b1);
    check_disp("negpt7", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h40, 8'hF8}, 1'b0);
    apply(20'd999999, 6'b0, 1'b0);
    check_disp("max", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}, 1'b0);
    apply(20'd1000000, 6'b0, 1'b0);
    check_disp("ovf_big", {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}, 1'b1);
    apply(20'd999999, 6'b0, 1'b1);
    check_disp("ovf_sign", {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}, 1'b1);
    wait_done();
    n = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.cvt_done;
    end
    chk("period", n, 32'd22);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", {26'd0, bus.sel}, 32'h3F);
    chk("mid_rst_seg", {24'd0, bus.seg}, 32'hFF);
    chk("mid_rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.cvt_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.cvt_done;
    end
    chk("rst_latency", n, 32'd22);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
